// File: rtl/hsv_core_ctrlstatus_arbiter_if.sv
// Bundle shared by the CSR arbiter: core and debug requesters, flush handshake
// and the register-block CPU interface. slave = arbiter view, master = environment view.
interface hsv_core_ctrlstatus_arbiter_if;
    logic        flush_req;
    logic        flush_ack;

    logic        core_req;
    logic        core_is_wr;
    logic [15:0] core_addr;
    logic [31:0] core_wr_data;
    logic [31:0] core_wr_biten;
    logic        core_gnt;
    logic        core_rsp_valid;
    logic        core_rsp_err;
    logic [31:0] core_rd_data;

    logic        dbg_req;
    logic        dbg_is_wr;
    logic [15:0] dbg_addr;
    logic [31:0] dbg_wr_data;
    logic [31:0] dbg_wr_biten;
    logic        dbg_gnt;
    logic        dbg_rsp_valid;
    logic        dbg_rsp_err;
    logic [31:0] dbg_rd_data;

    logic        regs_req;
    logic        regs_req_is_wr;
    logic [15:0] regs_addr;
    logic [31:0] regs_wr_data;
    logic [31:0] regs_wr_biten;
    logic        regs_req_stall_wr;
    logic        regs_req_stall_rd;
    logic        regs_rd_ack;
    logic        regs_rd_err;
    logic        regs_wr_ack;
    logic        regs_wr_err;
    logic [31:0] regs_rd_data;

    modport slave (
        input  flush_req,
        output flush_ack,
        input  core_req, core_is_wr, core_addr, core_wr_data, core_wr_biten,
        output core_gnt, core_rsp_valid, core_rsp_err, core_rd_data,
        input  dbg_req, dbg_is_wr, dbg_addr, dbg_wr_data, dbg_wr_biten,
        output dbg_gnt, dbg_rsp_valid, dbg_rsp_err, dbg_rd_data,
        output regs_req, regs_req_is_wr, regs_addr, regs_wr_data, regs_wr_biten,
        input  regs_req_stall_wr, regs_req_stall_rd,
        input  regs_rd_ack, regs_rd_err, regs_wr_ack, regs_wr_err, regs_rd_data
    );

    modport master (
        output flush_req,
        input  flush_ack,
        output core_req, core_is_wr, core_addr, core_wr_data, core_wr_biten,
        input  core_gnt, core_rsp_valid, core_rsp_err, core_rd_data,
        output dbg_req, dbg_is_wr, dbg_addr, dbg_wr_data, dbg_wr_biten,
        input  dbg_gnt, dbg_rsp_valid, dbg_rsp_err, dbg_rd_data,
        input  regs_req, regs_req_is_wr, regs_addr, regs_wr_data, regs_wr_biten,
        output regs_req_stall_wr, regs_req_stall_rd,
        output regs_rd_ack, regs_rd_err, regs_wr_ack, regs_wr_err, regs_rd_data
    );
endinterface

// File: rtl/hsv_core_ctrlstatus_arbiter.sv
// Two-requester (core / debug) arbiter for the CSR register-block CPU port, one
// transaction in flight. HSV_CORE_CSR_ARB_STARVE_GUARD_EN adds debug starvation guard.
module hsv_core_ctrlstatus_arbiter #(
    parameter int DBG_MAX_WAIT = 8
) (
    input logic                           clk_core,
    input logic                           rst_core_n,
    hsv_core_ctrlstatus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT_CORE, WAIT_DBG} state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_is_wr;
    logic   r_flush_ack;

    logic w_core_elig, w_dbg_elig, w_starve;
    logic w_idle, w_core_win, w_dbg_win, w_gnt_wr;
    logic w_ack_gnt, w_ack_wait;

    assign w_core_elig = bus.core_req & ~bus.flush_req &
                         ~(bus.core_is_wr ? bus.regs_req_stall_wr : bus.regs_req_stall_rd);
    assign w_dbg_elig  = bus.dbg_req &
                         ~(bus.dbg_is_wr ? bus.regs_req_stall_wr : bus.regs_req_stall_rd);

    // Reset qualifies the grant so every output is quiet while reset is held.
    assign w_idle     = (r_state == IDLE) & rst_core_n;
    assign w_dbg_win  = w_idle & w_dbg_elig & (~w_core_elig | w_starve);
    assign w_core_win = w_idle & w_core_elig & ~w_dbg_win;
    assign w_gnt_wr   = w_core_win ? bus.core_is_wr : bus.dbg_is_wr;
    assign w_ack_gnt  = w_gnt_wr ? bus.regs_wr_ack : bus.regs_rd_ack;
    assign w_ack_wait = r_is_wr  ? bus.regs_wr_ack : bus.regs_rd_ack;

`ifdef HSV_CORE_CSR_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(DBG_MAX_WAIT + 1);
    logic [CW-1:0] r_dbg_wait_cnt;

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            r_dbg_wait_cnt <= '0;
        end else if (bus.dbg_req && !w_dbg_win) begin
            if (r_dbg_wait_cnt != CW'(DBG_MAX_WAIT))
                r_dbg_wait_cnt <= r_dbg_wait_cnt + 1'b1;
        end else begin
            r_dbg_wait_cnt <= '0;
        end
    end

    assign w_starve = (r_dbg_wait_cnt == CW'(DBG_MAX_WAIT));
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (DBG_MAX_WAIT < 1);
    assign w_starve     = 1'b0;
`endif

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            r_state     <= IDLE;
            r_is_wr     <= 1'b0;
            r_flush_ack <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            if (w_core_win || w_dbg_win)
                r_is_wr <= w_gnt_wr;
            r_flush_ack <= bus.flush_req & (r_state != WAIT_CORE) & ~w_core_win;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_core_win && !w_ack_gnt)     w_state_nxt = WAIT_CORE;
                else if (w_dbg_win && !w_ack_gnt) w_state_nxt = WAIT_DBG;
            end
            WAIT_CORE, WAIT_DBG: begin
                if (w_ack_wait) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    logic w_rsp_core, w_rsp_dbg, w_rsp_wr;

    always_comb begin
        w_rsp_core = 1'b0;
        w_rsp_dbg  = 1'b0;
        w_rsp_wr   = 1'b0;
        case (r_state)
            IDLE: begin
                w_rsp_core = w_core_win & w_ack_gnt;
                w_rsp_dbg  = w_dbg_win  & w_ack_gnt;
                w_rsp_wr   = w_gnt_wr;
            end
            WAIT_CORE: begin
                w_rsp_core = w_ack_wait & rst_core_n;
                w_rsp_wr   = r_is_wr;
            end
            WAIT_DBG: begin
                w_rsp_dbg  = w_ack_wait & rst_core_n;
                w_rsp_wr   = r_is_wr;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.flush_ack      = r_flush_ack;
        bus.core_gnt       = w_core_win;
        bus.dbg_gnt        = w_dbg_win;
        bus.regs_req       = w_core_win | w_dbg_win;
        bus.regs_req_is_wr = 1'b0;
        bus.regs_addr      = '0;
        bus.regs_wr_data   = '0;
        bus.regs_wr_biten  = '0;
        if (w_core_win) begin
            bus.regs_req_is_wr = bus.core_is_wr;
            bus.regs_addr      = bus.core_addr;
            bus.regs_wr_data   = bus.core_wr_data;
            bus.regs_wr_biten  = bus.core_wr_biten;
        end else if (w_dbg_win) begin
            bus.regs_req_is_wr = bus.dbg_is_wr;
            bus.regs_addr      = bus.dbg_addr;
            bus.regs_wr_data   = bus.dbg_wr_data;
            bus.regs_wr_biten  = bus.dbg_wr_biten;
        end
        // Responses reach only the owner and only in the ack cycle.
        bus.core_rsp_valid = w_rsp_core;
        bus.core_rsp_err   = w_rsp_core & (w_rsp_wr ? bus.regs_wr_err : bus.regs_rd_err);
        bus.core_rd_data   = (w_rsp_core & ~w_rsp_wr) ? bus.regs_rd_data : 32'h0;
        bus.dbg_rsp_valid  = w_rsp_dbg;
        bus.dbg_rsp_err    = w_rsp_dbg & (w_rsp_wr ? bus.regs_wr_err : bus.regs_rd_err);
        bus.dbg_rd_data    = (w_rsp_dbg & ~w_rsp_wr) ? bus.regs_rd_data : 32'h0;
    end
endmodule

// File: tb/tb_hsv_core_ctrlstatus_arbiter.sv
// Bench for hsv_core_ctrlstatus_arbiter: directed table, corner sequences and a
// randomized run against a transaction-level model.
module tb_hsv_core_ctrlstatus_arbiter;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hsv_core_ctrlstatus_arbiter_if bus();

    hsv_core_ctrlstatus_arbiter #(.DBG_MAX_WAIT(MAXW)) dut (
        .clk_core   (clk),
        .rst_core_n (rst_n),
        .bus        (bus.slave)
    );

`ifdef HSV_CORE_CSR_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    int vecs = 0;
    int errs = 0;

    typedef struct { bit core; bit wr; } txn_t;
    txn_t pend[$];
    txn_t n_pend[$];
    int   wcnt = 0, n_wcnt = 0;
    bit   fack = 1'b0, n_fack = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        bus.flush_req = 0;
        bus.core_req = 0; bus.core_is_wr = 0; bus.core_addr = 0;
        bus.core_wr_data = 0; bus.core_wr_biten = 0;
        bus.dbg_req = 0; bus.dbg_is_wr = 0; bus.dbg_addr = 0;
        bus.dbg_wr_data = 0; bus.dbg_wr_biten = 0;
        bus.regs_req_stall_wr = 0; bus.regs_req_stall_rd = 0;
        bus.regs_rd_ack = 0; bus.regs_rd_err = 0;
        bus.regs_wr_ack = 0; bus.regs_wr_err = 0; bus.regs_rd_data = 0;
    endtask

    // Evaluate the model at mid-cycle, compare every output, stage the next model state.
    task automatic sample();
        logic e_cg, e_dg, e_cv, e_dv, e_ce, e_de, e_rq, e_rw;
        logic [31:0] e_crd, e_drd, e_wd, e_wb;
        logic [15:0] e_ra;
        logic [152:0] e, a;
        bit core_ok, dbg_ok, ack, rwr, rc, rv;
        int win;
        @(negedge clk);
        {e_cg, e_dg, e_cv, e_dv, e_ce, e_de, e_rq, e_rw} = '0;
        e_crd = 0; e_drd = 0; e_wd = 0; e_wb = 0; e_ra = 0;
        rv = 0; rc = 0; rwr = 0;
        n_pend = pend;
        if (!rst_n) begin
            n_pend = {};
            n_wcnt = 0;
            n_fack = 0;
        end else begin
            core_ok = bus.core_req && !bus.flush_req &&
                      !(bus.core_is_wr ? bus.regs_req_stall_wr : bus.regs_req_stall_rd);
            dbg_ok  = bus.dbg_req &&
                      !(bus.dbg_is_wr ? bus.regs_req_stall_wr : bus.regs_req_stall_rd);
            if (pend.size() == 0) begin
                win = 0;
                if (GUARD && wcnt == MAXW && dbg_ok) win = 2;
                else if (core_ok) win = 1;
                else if (dbg_ok) win = 2;
                if (win != 0) begin
                    e_rq = 1;
                    e_cg = (win == 1);
                    e_dg = (win == 2);
                    e_rw = e_cg ? bus.core_is_wr : bus.dbg_is_wr;
                    e_ra = e_cg ? bus.core_addr : bus.dbg_addr;
                    e_wd = e_cg ? bus.core_wr_data : bus.dbg_wr_data;
                    e_wb = e_cg ? bus.core_wr_biten : bus.dbg_wr_biten;
                    ack  = e_rw ? bus.regs_wr_ack : bus.regs_rd_ack;
                    if (ack) begin rv = 1; rc = e_cg; rwr = e_rw; end
                    else n_pend.push_back('{core: e_cg, wr: e_rw});
                end
            end else begin
                ack = pend[0].wr ? bus.regs_wr_ack : bus.regs_rd_ack;
                if (ack) begin
                    rv = 1; rc = pend[0].core; rwr = pend[0].wr;
                    void'(n_pend.pop_front());
                end
            end
            if (rv) begin
                if (rc) begin
                    e_cv = 1; e_ce = rwr ? bus.regs_wr_err : bus.regs_rd_err;
                    e_crd = rwr ? 32'h0 : bus.regs_rd_data;
                end else begin
                    e_dv = 1; e_de = rwr ? bus.regs_wr_err : bus.regs_rd_err;
                    e_drd = rwr ? 32'h0 : bus.regs_rd_data;
                end
            end
            n_wcnt = (bus.dbg_req && !e_dg) ? ((wcnt + 1 > MAXW) ? MAXW : wcnt + 1) : 0;
            n_fack = bus.flush_req && !(pend.size() != 0 && pend[0].core) && !e_cg;
        end
        e = {(rst_n ? fack : 1'b0), e_cg, e_dg, e_cv, e_dv, e_ce, e_de, e_crd, e_drd,
             e_rq, e_rw, e_ra, e_wd, e_wb};
        a = {bus.flush_ack, bus.core_gnt, bus.dbg_gnt, bus.core_rsp_valid, bus.dbg_rsp_valid,
             bus.core_rsp_err, bus.dbg_rsp_err, bus.core_rd_data, bus.dbg_rd_data,
             bus.regs_req, bus.regs_req_is_wr, bus.regs_addr, bus.regs_wr_data, bus.regs_wr_biten};
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL model: got %h expected %h (t=%0t)", a, e, $time);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        pend = n_pend;
        wcnt = n_wcnt;
        fack = n_fack;
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    typedef struct {
        logic        creq, cwr;
        logic [15:0] caddr;
        logic        dreq, dwr;
        logic [15:0] daddr;
        logic        flush, stw, str;
        logic        e_cg, e_dg, e_wr;
        logic [15:0] e_addr;
    } vec_t;

    vec_t tbl[10];

    initial begin
        idle_in();
        #1;
        // reset state
        sample();
        chk("rst_regs_req", 32'(bus.regs_req), 0);
        chk("rst_flush_ack", 32'(bus.flush_ack), 0);
        advance();
        step();
        rst_n = 1'b1;
        step();

        tbl[0] = '{1,0,16'h0F14, 0,0,16'h0000, 0,0,0, 1,0,0,16'h0F14};
        tbl[1] = '{0,0,16'h0000, 1,1,16'h0300, 0,0,0, 0,1,1,16'h0300};
        tbl[2] = '{1,1,16'h0010, 1,0,16'h0020, 0,0,0, 1,0,1,16'h0010};
        tbl[3] = '{1,1,16'h0010, 1,0,16'h0020, 0,1,0, 0,1,0,16'h0020};
        tbl[4] = '{1,0,16'h0011, 1,1,16'h0021, 0,0,1, 0,1,1,16'h0021};
        tbl[5] = '{1,0,16'h0012, 1,0,16'h0022, 1,0,0, 0,1,0,16'h0022};
        tbl[6] = '{1,0,16'h0013, 0,0,16'h0000, 1,0,0, 0,0,0,16'h0000};
        tbl[7] = '{1,0,16'h0014, 1,1,16'h0024, 0,1,1, 0,0,0,16'h0000};
        tbl[8] = '{1,0,16'h0015, 0,0,16'h0000, 0,1,0, 1,0,0,16'h0015};
        tbl[9] = '{0,0,16'h0000, 1,1,16'h0026, 0,1,0, 0,0,0,16'h0000};
        for (int i = 0; i < 10; i++) begin
            idle_in();
            bus.core_req = tbl[i].creq; bus.core_is_wr = tbl[i].cwr; bus.core_addr = tbl[i].caddr;
            bus.dbg_req = tbl[i].dreq; bus.dbg_is_wr = tbl[i].dwr; bus.dbg_addr = tbl[i].daddr;
            bus.flush_req = tbl[i].flush;
            bus.regs_req_stall_wr = tbl[i].stw; bus.regs_req_stall_rd = tbl[i].str;
            bus.regs_rd_ack = 1; bus.regs_wr_ack = 1; bus.regs_rd_err = 1;
            bus.regs_rd_data = 32'h5A5A_0000 | 32'(i);
            sample();
            chk($sformatf("tbl%0d_core_gnt", i), 32'(bus.core_gnt), 32'(tbl[i].e_cg));
            chk($sformatf("tbl%0d_dbg_gnt", i), 32'(bus.dbg_gnt), 32'(tbl[i].e_dg));
            chk($sformatf("tbl%0d_is_wr", i), 32'(bus.regs_req_is_wr), 32'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_addr", i), 32'(bus.regs_addr), 32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_core_rv", i), 32'(bus.core_rsp_valid), 32'(tbl[i].e_cg));
            chk($sformatf("tbl%0d_dbg_rv", i), 32'(bus.dbg_rsp_valid), 32'(tbl[i].e_dg));
            advance();
            idle_in();
            step();
        end

        // core read 0xF14, same-cycle ack, then a read with nonzero data
        idle_in();
        bus.core_req = 1; bus.core_addr = 16'h0F14; bus.regs_rd_ack = 1;
        sample();
        chk("f14_gnt", 32'(bus.core_gnt), 1);
        chk("f14_rv", 32'(bus.core_rsp_valid), 1);
        chk("f14_rd", bus.core_rd_data, 0);
        advance();
        bus.core_addr = 16'h0300; bus.regs_rd_data = 32'hDEADBEEF;
        sample();
        chk("rd_data", bus.core_rd_data, 32'hDEADBEEF);
        chk("rd_dbg_quiet", bus.dbg_rd_data, 0);
        advance();
        idle_in();
        sample();
        chk("f14_after_rv", 32'(bus.core_rsp_valid), 0);
        advance();

        // debug write, ack 3 cycles later with error; core waits
        bus.dbg_req = 1; bus.dbg_is_wr = 1; bus.dbg_addr = 16'h0300;
        bus.dbg_wr_data = 32'h8; bus.dbg_wr_biten = 32'hFFFF_FFFF;
        sample();
        chk("dw_gnt", 32'(bus.dbg_gnt), 1);
        chk("dw_data", bus.regs_wr_data, 32'h8);
        chk("dw_is_wr", 32'(bus.regs_req_is_wr), 1);
        advance();
        idle_in();
        bus.core_req = 1; bus.core_addr = 16'h0001;
        for (int c = 1; c <= 2; c++) begin
            sample();
            chk($sformatf("dw_c%0d_core_gnt", c), 32'(bus.core_gnt), 0);
            chk($sformatf("dw_c%0d_regs_req", c), 32'(bus.regs_req), 0);
            advance();
        end
        bus.regs_wr_ack = 1; bus.regs_wr_err = 1;
        sample();
        chk("dw_rv", 32'(bus.dbg_rsp_valid), 1);
        chk("dw_err", 32'(bus.dbg_rsp_err), 1);
        chk("dw_rd0", bus.dbg_rd_data, 0);
        chk("dw_ackcyc_core_gnt", 32'(bus.core_gnt), 0);
        advance();
        bus.regs_wr_ack = 0; bus.regs_wr_err = 0;
        sample();
        chk("c4_core_gnt", 32'(bus.core_gnt), 1);
        chk("c4_addr", 32'(bus.regs_addr), 32'h0001);
        advance();
        idle_in();
        bus.regs_rd_ack = 1; bus.regs_rd_data = 32'h1234_5678;
        sample();
        chk("c5_core_rv", 32'(bus.core_rsp_valid), 1);
        chk("c5_core_rd", bus.core_rd_data, 32'h1234_5678);
        chk("c5_dbg_rv", 32'(bus.dbg_rsp_valid), 0);
        advance();
        idle_in();
        step();

        // both requesters saturating, same-cycle acks
        bus.core_req = 1; bus.core_addr = 16'h0100;
        bus.dbg_req = 1; bus.dbg_addr = 16'h0200;
        bus.regs_rd_ack = 1; bus.regs_wr_ack = 1;
        for (int k = 0; k < 10; k++) begin
            sample();
            chk($sformatf("sat%0d_dbg_gnt", k), 32'(bus.dbg_gnt), 32'(GUARD && (k % 5 == 4)));
            chk($sformatf("sat%0d_core_gnt", k), 32'(bus.core_gnt), 32'(!(GUARD && (k % 5 == 4))));
            advance();
        end
        idle_in();
        step();

        // flush while a core read is outstanding
        bus.core_req = 1; bus.core_addr = 16'h0C00;
        sample();
        chk("fl_c0_gnt", 32'(bus.core_gnt), 1);
        advance();
        bus.flush_req = 1;
        for (int c = 1; c <= 5; c++) begin
            bus.regs_rd_ack = (c == 3);
            sample();
            chk($sformatf("fl_c%0d_gnt", c), 32'(bus.core_gnt), 0);
            chk($sformatf("fl_c%0d_ack", c), 32'(bus.flush_ack), 32'(c == 5));
            chk($sformatf("fl_c%0d_rv", c), 32'(bus.core_rsp_valid), 32'(c == 3));
            advance();
        end
        bus.flush_req = 0; bus.regs_rd_ack = 1;
        sample();
        chk("fl_c6_gnt", 32'(bus.core_gnt), 1);
        chk("fl_c6_ack", 32'(bus.flush_ack), 1);
        advance();
        idle_in();
        sample();
        chk("fl_c7_ack", 32'(bus.flush_ack), 0);
        advance();

        // write stall lets the lower-priority read through
        bus.core_req = 1; bus.core_is_wr = 1; bus.core_addr = 16'h0340;
        bus.dbg_req = 1; bus.dbg_addr = 16'h0341;
        bus.regs_req_stall_wr = 1; bus.regs_rd_ack = 1;
        sample();
        chk("stall_dbg_gnt", 32'(bus.dbg_gnt), 1);
        chk("stall_core_gnt", 32'(bus.core_gnt), 0);
        advance();
        idle_in();
        step();

        // reset while WAIT_DBG, late ack dropped
        bus.dbg_req = 1; bus.dbg_addr = 16'h0B00;
        sample();
        chk("rw_dbg_gnt", 32'(bus.dbg_gnt), 1);
        advance();
        rst_n = 1'b0;
        bus.core_req = 1; bus.regs_rd_ack = 1; bus.regs_wr_ack = 1;
        bus.regs_rd_data = 32'hFFFF_FFFF; bus.regs_rd_err = 1;
        for (int c = 0; c < 2; c++) begin
            sample();
            chk($sformatf("inrst%0d_gnt", c), 32'({bus.core_gnt, bus.dbg_gnt, bus.regs_req}), 0);
            chk($sformatf("inrst%0d_rv", c), 32'({bus.core_rsp_valid, bus.dbg_rsp_valid}), 0);
            chk($sformatf("inrst%0d_rd", c), bus.dbg_rd_data | bus.core_rd_data, 0);
            chk($sformatf("inrst%0d_addr", c), 32'(bus.regs_addr), 0);
            advance();
        end
        rst_n = 1'b1;
        bus.core_req = 0; bus.dbg_req = 0;
        sample();
        chk("late_ack_dbg_rv", 32'(bus.dbg_rsp_valid), 0);
        chk("late_ack_core_rv", 32'(bus.core_rsp_valid), 0);
        advance();
        idle_in();
        step();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            bus.flush_req = ($urandom_range(0, 7) == 0);
            bus.core_req = $urandom_range(0, 1); bus.core_is_wr = $urandom_range(0, 1);
            bus.core_addr = 16'($urandom); bus.core_wr_data = $urandom;
            bus.core_wr_biten = $urandom;
            bus.dbg_req = $urandom_range(0, 1); bus.dbg_is_wr = $urandom_range(0, 1);
            bus.dbg_addr = 16'($urandom); bus.dbg_wr_data = $urandom;
            bus.dbg_wr_biten = $urandom;
            bus.regs_req_stall_wr = ($urandom_range(0, 3) == 0);
            bus.regs_req_stall_rd = ($urandom_range(0, 3) == 0);
            bus.regs_rd_ack = $urandom_range(0, 1); bus.regs_wr_ack = $urandom_range(0, 1);
            bus.regs_rd_err = $urandom_range(0, 1); bus.regs_wr_err = $urandom_range(0, 1);
            bus.regs_rd_data = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
